// File: rtl/acc_cpu_gen2_pkg.sv
// acc_cpu_gen2_pkg: shared opcodes, FSM state encoding and instruction field
// position helpers for the second-generation accumulator CPU.
// Optional feature macro used by the design: ACC_CPU_GEN2_IND_EN (indirect addressing).
package acc_cpu_gen2_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOT = 3'b000;
  localparam logic [OP_W-1:0] OP_ADC = 3'b001;
  localparam logic [OP_W-1:0] OP_JPA = 3'b010;
  localparam logic [OP_W-1:0] OP_INC = 3'b011;
  localparam logic [OP_W-1:0] OP_STA = 3'b100;
  localparam logic [OP_W-1:0] OP_LDA = 3'b101;
  localparam logic [OP_W-1:0] OP_CLC = 3'b110;
  localparam logic [OP_W-1:0] OP_HLT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_IND    = 3'd3,
    S_OPRD   = 3'd4,
    S_EXEC   = 3'd5,
    S_STORE  = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  // Lowest bit of the opcode field in a DW-wide instruction word.
  function automatic int op_lsb(input int dw);
    return dw - OP_W;
  endfunction

  // Position of the addressing-mode bit (1 = indirect), just below the opcode.
  function automatic int am_pos(input int dw);
    return dw - OP_W - 1;
  endfunction

endpackage

// File: rtl/acc_cpu_gen2_alu.sv
// acc_cpu_gen2_alu: combinational execute stage. Produces the accumulator and
// carry values to be written back at the end of the EXEC state.
module acc_cpu_gen2_alu
  import acc_cpu_gen2_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [2:0]    opcode,
  input  logic [DW-1:0] ac,
  input  logic [DW-1:0] md,
  input  logic          carry,
  output logic [DW-1:0] ac_nxt,
  output logic          carry_nxt
);

  logic [DW:0] sum_inc;
  logic [DW:0] sum_adc;

  // Both sums are formed one bit wider so the top bit is the carry out.
  assign sum_inc = {1'b0, ac} + {{DW{1'b0}}, 1'b1};
  assign sum_adc = {1'b0, ac} + {1'b0, md} + {{DW{1'b0}}, carry};

  // Select the write-back value per opcode; anything else leaves ac/carry alone.
  always_comb begin
    ac_nxt    = ac;
    carry_nxt = carry;
    case (opcode)
      OP_NOT: ac_nxt = ~ac;
      OP_INC: {carry_nxt, ac_nxt} = sum_inc;
      OP_ADC: {carry_nxt, ac_nxt} = sum_adc;
      OP_LDA: ac_nxt = md;
      OP_CLC: carry_nxt = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: rtl/acc_cpu_gen2.sv
// acc_cpu_gen2: multi-cycle accumulator CPU with one shared memory port.
// Memory handshake: a request (mem_addr/mem_re/mem_we/mem_wdata) is a Moore
// output of the current state and stays stable until a rising edge with
// mem_ready=1, which completes it (read data is sampled on that same edge).
// mem_re and mem_we are never asserted together.
// Optional feature: define ACC_CPU_GEN2_IND_EN to honour the AM bit and build
// the IND state; otherwise all addressing is direct.
// DW must be at least AW+4 so the opcode, AM bit and operand do not overlap.
module acc_cpu_gen2
  import acc_cpu_gen2_pkg::*;
#(
  parameter int            DW       = 16,
  parameter int            AW       = 12,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic [DW-1:0] ac,
  output logic          carry,
  output logic [AW-1:0] pc,
  output logic          halted
);

  localparam int OP_LSB = op_lsb(DW);
  localparam int AM_BIT = am_pos(DW);

  state_t        state_q;
  state_t        state_d;
  logic [DW-1:0] ir;
  logic [AW-1:0] ma;
  logic [DW-1:0] md;

  logic [2:0]    opcode;
  logic          am;
  logic [AW-1:0] operand;
  logic          ac_pos;
  logic          mem_op;
  logic [AW-1:0] pc_inc;
  logic [DW-1:0] alu_ac;
  logic          alu_carry;
  logic          unused_ir;

  assign opcode  = ir[OP_LSB +: 3];
  assign operand = ir[AW-1:0];
`ifdef ACC_CPU_GEN2_IND_EN
  assign am = ir[AM_BIT];
`else
  assign am = 1'b0;
`endif
  // Bits between the AM bit and the operand field carry no meaning.
  assign unused_ir = ^ir;

  // Jump condition: signed-positive means MSB clear and not zero.
  assign ac_pos = ~ac[DW-1] & (|ac);
  assign mem_op = (opcode == OP_STA) || (opcode == OP_LDA) || (opcode == OP_ADC);
  assign pc_inc = pc + {{(AW-1){1'b0}}, 1'b1};
  assign halted = (state_q == S_HALT);

  acc_cpu_gen2_alu #(.DW(DW)) u_alu (
    .opcode    (opcode),
    .ac        (ac),
    .md        (md),
    .carry     (carry),
    .ac_nxt    (alu_ac),
    .carry_nxt (alu_carry)
  );

  // FSM state register; reset abandons any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode; memory states advance only when mem_ready completes them.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_NOT, OP_INC, OP_CLC: state_d = S_EXEC;
          OP_HLT:                 state_d = S_HALT;
          OP_JPA:                 state_d = (ac_pos && am) ? S_IND : S_FETCH;
          default: begin
            if (am)                    state_d = S_IND;
            else if (opcode == OP_STA) state_d = S_STORE;
            else                       state_d = S_OPRD;
          end
        endcase
      end
`ifdef ACC_CPU_GEN2_IND_EN
      S_IND: begin
        if (mem_ready) begin
          if (opcode == OP_JPA)      state_d = S_FETCH;
          else if (opcode == OP_STA) state_d = S_STORE;
          else                       state_d = S_OPRD;
        end
      end
`endif
      S_OPRD:  if (mem_ready) state_d = S_EXEC;
      S_EXEC:  state_d = S_FETCH;
      S_STORE: if (mem_ready) state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore memory strobes: the request is a pure function of the current state.
  always_comb begin
    mem_addr  = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state_q)
      S_FETCH: begin
        mem_addr = pc;
        mem_re   = 1'b1;
      end
`ifdef ACC_CPU_GEN2_IND_EN
      S_IND: begin
        mem_addr = operand;
        mem_re   = 1'b1;
      end
`endif
      S_OPRD: begin
        mem_addr = ma;
        mem_re   = 1'b1;
      end
      S_STORE: begin
        mem_addr  = ma;
        mem_we    = 1'b1;
        mem_wdata = ac;
      end
      default: ;
    endcase
  end

  // Architectural and internal registers, updated per state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac    <= '0;
      carry <= 1'b0;
      pc    <= RESET_PC;
      ir    <= '0;
      ma    <= '0;
      md    <= '0;
    end else begin
      case (state_q)
        S_FETCH: if (mem_ready) ir <= mem_rdata;
        S_DECODE: begin
          if ((opcode == OP_JPA) && ac_pos && !am) pc <= operand;
          else                                     pc <= pc_inc;
          if (mem_op) ma <= operand;
        end
`ifdef ACC_CPU_GEN2_IND_EN
        S_IND: begin
          if (mem_ready) begin
            if (opcode == OP_JPA) pc <= mem_rdata[AW-1:0];
            else                  ma <= mem_rdata[AW-1:0];
          end
        end
`endif
        S_OPRD: if (mem_ready) md <= mem_rdata;
        S_EXEC: begin
          ac    <= alu_ac;
          carry <= alu_carry;
        end
        default: ;
      endcase
    end
  end

endmodule
